// File: rtl/ixc_rev_assign_pipe.sv
// Registered L->R return path with valid/ready on both sides and a 2-entry skid buffer.
// Optional parity transport and sticky error flag when IXC_REV_ASSIGN_PARITY_EN is defined.
module ixc_rev_assign_pipe #(
    parameter int WIDTH = 14,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] l_data,
    input  logic             l_valid,
    output logic             l_ready,
    output logic [WIDTH-1:0] r_data,
    output logic             r_valid,
    input  logic             r_ready,
`ifdef IXC_REV_ASSIGN_PARITY_EN
    input  logic             l_par,
    output logic             r_par,
    output logic             par_err,
`endif
    output logic [CNT_W-1:0] xfer_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] skid_data_p1;
    logic             push;
    logic             pop;
    logic             ld_r_from_l;
    logic             ld_r_from_skid;
    logic             ld_skid;

    assign push = l_valid & l_ready;
    assign pop  = r_valid & r_ready;

    // State register plus the registered handshake outputs derived from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= EMPTY;
            r_valid <= 1'b0;
            l_ready <= 1'b0;
        end else begin
            state   <= state_nxt;
            r_valid <= (state_nxt != EMPTY);
            l_ready <= (state_nxt != TWO);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (push) state_nxt = ONE;
            ONE: begin
                if (push && !pop)      state_nxt = TWO;
                else if (!push && pop) state_nxt = EMPTY;
                else                   state_nxt = ONE;
            end
            TWO:     if (pop) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    // Datapath load selects; nothing loads without a push, so idle l_data never lands
    always_comb begin
        ld_r_from_l    = 1'b0;
        ld_r_from_skid = 1'b0;
        ld_skid        = 1'b0;
        case (state)
            EMPTY: ld_r_from_l = push;
            ONE: begin
                ld_r_from_l = push & pop;
                ld_skid     = push & ~pop;
            end
            TWO:     ld_r_from_skid = pop;
            default: ;
        endcase
    end

    // Output and skid stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data       <= '0;
            skid_data_p1 <= '0;
        end else begin
            if (ld_r_from_l)         r_data <= l_data;
            else if (ld_r_from_skid) r_data <= skid_data_p1;
            if (ld_skid)             skid_data_p1 <= l_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) xfer_cnt <= '0;
        else if (pop) xfer_cnt <= xfer_cnt + 1'b1;
    end

`ifdef IXC_REV_ASSIGN_PARITY_EN
    function automatic logic even_par(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction

    logic skid_par_p1;

    // Parity bit rides alongside its word through both entries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par       <= 1'b0;
            skid_par_p1 <= 1'b0;
            par_err     <= 1'b0;
        end else begin
            if (ld_r_from_l)         r_par <= l_par;
            else if (ld_r_from_skid) r_par <= skid_par_p1;
            if (ld_skid)             skid_par_p1 <= l_par;
            if (push && (even_par(l_data) != l_par)) par_err <= 1'b1;
        end
    end
`endif

endmodule
